fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 fetch_unit SHALL expose parameters AW=8 (instruction address width), IW=9 (instruction width) and DEPTH=2 (fetch buffer entries).
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  level; leaves IDLE, begins fetch at address 0.
REQ-005 rom_addr  out  AW  address to the combinational instruction ROM.
REQ-006 rom_data  in  IW  ROM word at rom_addr, valid in the same cycle.
REQ-007 instr_out  out  IW  instruction at buffer head.
REQ-008 pc_out  out  AW  address of instr_out.
REQ-009 instr_valid  out  1  buffer head holds a valid instruction.
REQ-010 instr_ready  in  1  downstream accepts the head this cycle.
REQ-011 branch_en, taken  in  1 each  qualify a redirect on the accepted instruction.
REQ-012 rel_jump  in  AW  signed two's-complement branch offset.
REQ-013 halt  out  1  program finished.

Function
REQ-014 The block SHALL contain exactly these states: IDLE, RUN, HALTED.
REQ-015 IDLE: fetch_pc SHALL be 0, the buffer SHALL be empty, and the block SHALL go to RUN in the cycle after start=1 is sampled.
REQ-016 RUN: rom_addr SHALL equal fetch_pc.
REQ-016a RUN, buffer not full or head accepted this cycle: the block SHALL push {rom_data, fetch_pc} and increment fetch_pc modulo 256 (8'hFF -> 8'h00).
REQ-017 Latency: a word addressed at cycle N SHALL appear on instr_out no earlier than cycle N+1.
REQ-018 Accept: an instruction SHALL be accepted exactly when instr_valid=1 and instr_ready=1.
REQ-018a instr_out and pc_out SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-019 Full buffer with a same-cycle accept SHALL push and pop together, leaving occupancy unchanged.
REQ-019a An empty buffer SHALL force instr_valid=0.
REQ-020 Redirect: an accept with branch_en=1 and taken=1 SHALL flush all buffer entries and load fetch_pc <= pc_out + rel_jump (8-bit wrap).
REQ-020a On such a redirect, no push SHALL occur that cycle and instr_valid SHALL be 0 the next cycle.
REQ-021 branch_en=1 with taken=0, or either signal without an accept, SHALL have no effect.
REQ-022 Accepting instr_out == HALT_OP (9'h1FF) SHALL move the block to HALTED, flush the buffer and stop fetching.
REQ-022a HALT_OP SHALL take priority over a simultaneous redirect.
REQ-023 HALTED: halt=1 and instr_valid=0; HALTED SHALL go to IDLE once start=0 is sampled.
REQ-023a start=1 SHALL be ignored in RUN and in HALTED.
REQ-024 halt SHALL be a registered output and SHALL be 0 in IDLE and RUN.

Reset
REQ-025 rst_n=0 SHALL, asynchronously and at any point in operation, force state=IDLE, fetch_pc=0, buffer empty, instr_valid=0, halt=0, rom_addr=0, instr_out=0, pc_out=0.
REQ-026 After rst_n deasserts, the first state change SHALL occur on the first CLK edge at which start=1.

Structure
REQ-027 A shared package fetch_pkg SHALL hold AW, IW, DEPTH, HALT_OP and the state enum type.
REQ-028 The buffer SHALL be a sub-module fetch_fifo with push, pop, flush, full and empty ports and a {instr, pc} payload.
REQ-029 fetch_fifo SHALL reset asynchronously on rst_n.

Verification
REQ-030 Reset, start=1, instr_ready=1, ROM[0..3]=9'h010..9'h013 -> pc_out 0,1,2,3 on consecutive cycles starting two cycles after start, instr_out matching.
REQ-031 instr_ready=0 for 5 cycles in RUN -> the buffer holds 2 entries, rom_addr freezes at 2, instr_out/pc_out stable at 9'h010/0; releasing ready yields 0,1,2 with no gap or duplicate.
REQ-032 Accept at pc_out=5 with branch_en=1, taken=1, rel_jump=8'hFC -> flush, instr_valid=0 for one cycle, next pc_out=1.
REQ-033 Jump to 8'hFE with ready held high -> pc_out sequence FE, FF, 00.
REQ-034 ROM[3]=9'h1FF with branch_en=1, taken=1 -> halt=1 the cycle after the accept, no redirect, instr_valid=0; start=0 -> IDLE; start=1 -> restart at 0.
REQ-035 rst_n pulsed low mid-RUN with a full buffer -> all outputs 0 immediately without a CLK edge; no activity until start=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared sizing constants, halt opcode and state type for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned AW    = 8;
    localparam int unsigned IW    = 9;
    localparam int unsigned DEPTH = 2;

    localparam logic [IW-1:0] HALT_OP = 9'h1FF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalted
    } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch buffer holding {instr, pc} entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full buffer may still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a combinational ROM into a small buffer, handles
// taken-branch redirects and a halt opcode.
module fetch_unit #(
    parameter int unsigned AW    = fetch_pkg::AW,
    parameter int unsigned IW    = fetch_pkg::IW,
    parameter int unsigned DEPTH = fetch_pkg::DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic [AW-1:0] o_rom_addr,
    input  logic [IW-1:0] i_rom_data,
    output logic [IW-1:0] o_instr_out,
    output logic [AW-1:0] o_pc_out,
    output logic          o_instr_valid,
    input  logic          i_instr_ready,
    input  logic          i_branch_en,
    input  logic          i_taken,
    input  logic [AW-1:0] i_rel_jump,
    output logic          o_halt
);

    import fetch_pkg::*;

    state_e           r_state;
    state_e           w_state_d;
    logic [AW-1:0]    r_fetch_pc;
    logic [AW-1:0]    w_fetch_pc_d;
    logic             r_halt;
    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_is_halt;
    logic             w_redirect;
    logic             w_push;
    logic             w_flush;
    logic [IW+AW-1:0] w_head;

    fetch_fifo #(
        .W     (IW + AW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_accept),
        .i_flush (w_flush),
        .i_data  ({i_rom_data, r_fetch_pc}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Head is masked while empty so stale storage never shows on the outputs.
    assign o_instr_valid = !w_empty;
    assign o_instr_out   = w_empty ? '0 : w_head[IW+AW-1:AW];
    assign o_pc_out      = w_empty ? '0 : w_head[AW-1:0];
    assign o_rom_addr    = r_fetch_pc;
    assign o_halt        = r_halt;

    assign w_accept   = o_instr_valid && i_instr_ready;
    assign w_is_halt  = w_accept && (o_instr_out == HALT_OP);
    assign w_redirect = w_accept && i_branch_en && i_taken && !w_is_halt;

    always_comb begin
        w_state_d    = r_state;
        w_fetch_pc_d = r_fetch_pc;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            StIdle: begin
                w_fetch_pc_d = '0;
                if (i_start) w_state_d = StRun;
            end
            StRun: begin
                if (w_is_halt) begin
                    w_state_d    = StHalted;
                    w_flush      = 1'b1;
                    w_fetch_pc_d = '0;
                end else if (w_redirect) begin
                    w_flush      = 1'b1;
                    w_fetch_pc_d = o_pc_out + i_rel_jump;
                end else if (!w_full || w_accept) begin
                    w_push       = 1'b1;
                    w_fetch_pc_d = r_fetch_pc + AW'(1);
                end
            end
            StHalted: begin
                if (!i_start) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_fetch_pc <= '0;
            r_halt     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_fetch_pc <= w_fetch_pc_d;
            r_halt     <= (w_state_d == StHalted);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stalls, redirects, wrap, halt and async reset.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_start;
    logic [7:0] o_rom_addr;
    logic [8:0] i_rom_data;
    logic [8:0] o_instr_out;
    logic [7:0] o_pc_out;
    logic       o_instr_valid;
    logic       i_instr_ready;
    logic       i_branch_en;
    logic       i_taken;
    logic [7:0] i_rel_jump;
    logic       o_halt;

    logic [8:0] rom [256];
    int         n_tests = 0;
    int         n_fail  = 0;

    assign i_rom_data = rom[o_rom_addr];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .o_rom_addr    (o_rom_addr),
        .i_rom_data    (i_rom_data),
        .o_instr_out   (o_instr_out),
        .o_pc_out      (o_pc_out),
        .o_instr_valid (o_instr_valid),
        .i_instr_ready (i_instr_ready),
        .i_branch_en   (i_branch_en),
        .i_taken       (i_taken),
        .i_rel_jump    (i_rel_jump),
        .o_halt        (o_halt)
    );

    task automatic do_reset();
        @(negedge clk);
        i_start = 0; i_instr_ready = 0; i_branch_en = 0; i_taken = 0; i_rel_jump = 0;
        rst_n = 0;
        #1 rst_n = 1;
    endtask

    // Leaves the bench on the negedge of the first RUN cycle.
    task automatic start_run();
        i_start = 1;
        @(negedge clk);
        i_start = 0;
    endtask

    task automatic wait_pc(input logic [7:0] pc);
        int n = 0;
        while (!(o_instr_valid === 1'b1 && o_pc_out === pc) && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (o_pc_out !== pc) begin
            n_fail++; $display("FAIL wait_pc got %h exp %h", o_pc_out, pc);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; i_start = 0; i_instr_ready = 0; i_branch_en = 0; i_taken = 0; i_rel_jump = 0;
        #2;
        n_tests++;
        if ({o_instr_valid, o_halt, o_rom_addr, o_instr_out, o_pc_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b h=%b a=%h i=%h p=%h exp all 0",
                     o_instr_valid, o_halt, o_rom_addr, o_instr_out, o_pc_out);
        end
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (o_instr_valid !== 1'b0 || o_rom_addr !== 8'h00 || o_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got v=%b a=%h h=%b exp 0 00 0",
                     o_instr_valid, o_rom_addr, o_halt);
        end
    endtask

    task automatic test_stream();
        do_reset();
        i_instr_ready = 1;
        start_run();
        n_tests++;
        if (o_instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_latency valid got %b exp 0", o_instr_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (o_instr_valid !== 1'b1 || o_pc_out !== 8'(i) || o_instr_out !== 9'(16 + i)) begin
                n_fail++;
                $display("FAIL stream_%0d got v=%b pc=%h instr=%h exp 1 %h %h",
                         i, o_instr_valid, o_pc_out, o_instr_out, 8'(i), 9'(16 + i));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        start_run();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (o_instr_valid !== 1'b1 || o_pc_out !== 8'h00 || o_instr_out !== 9'h010) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got v=%b pc=%h instr=%h exp 1 00 010",
                         i, o_instr_valid, o_pc_out, o_instr_out);
            end
        end
        n_tests++;
        if (o_rom_addr !== 8'h02) begin
            n_fail++; $display("FAIL stall_rom_addr got %h exp 02", o_rom_addr);
        end
        i_instr_ready = 1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (o_instr_valid !== 1'b1 || o_pc_out !== 8'(i)) begin
                n_fail++;
                $display("FAIL stall_release_%0d got v=%b pc=%h exp 1 %h",
                         i, o_instr_valid, o_pc_out, 8'(i));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        do_reset();
        i_instr_ready = 1;
        start_run();
        wait_pc(8'h03);
        i_branch_en = 1; i_taken = 0; i_rel_jump = 8'hFC;
        @(negedge clk);
        i_branch_en = 0; i_rel_jump = 8'h00;
        n_tests++;
        if (o_instr_valid !== 1'b1 || o_pc_out !== 8'h04) begin
            n_fail++;
            $display("FAIL branch_not_taken got v=%b pc=%h exp 1 04", o_instr_valid, o_pc_out);
        end
        wait_pc(8'h05);
        i_branch_en = 1; i_taken = 1; i_rel_jump = 8'hFC;
        @(negedge clk);
        i_branch_en = 0; i_taken = 0; i_rel_jump = 8'h00;
        n_tests++;
        if (o_instr_valid !== 1'b0 || o_rom_addr !== 8'h01) begin
            n_fail++;
            $display("FAIL branch_flush got v=%b addr=%h exp 0 01", o_instr_valid, o_rom_addr);
        end
        @(negedge clk);
        n_tests++;
        if (o_instr_valid !== 1'b1 || o_pc_out !== 8'h01 || o_instr_out !== 9'h011) begin
            n_fail++;
            $display("FAIL branch_target got v=%b pc=%h instr=%h exp 1 01 011",
                     o_instr_valid, o_pc_out, o_instr_out);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [3];
        logic [8:0] exp_in [3];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
        exp_in[0] = 9'h10E; exp_in[1] = 9'h10F; exp_in[2] = 9'h010;
        do_reset();
        i_instr_ready = 1;
        start_run();
        wait_pc(8'h02);
        i_branch_en = 1; i_taken = 1; i_rel_jump = 8'hFC;
        @(negedge clk);
        i_branch_en = 0; i_taken = 0; i_rel_jump = 8'h00;
        n_tests++;
        if (o_instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL wrap_flush valid got %b exp 0", o_instr_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (o_instr_valid !== 1'b1 || o_pc_out !== exp_pc[i] || o_instr_out !== exp_in[i]) begin
                n_fail++;
                $display("FAIL wrap_%0d got v=%b pc=%h instr=%h exp 1 %h %h",
                         i, o_instr_valid, o_pc_out, o_instr_out, exp_pc[i], exp_in[i]);
            end
        end
    endtask

    task automatic test_halt();
        rom[3] = 9'h1FF;
        do_reset();
        i_instr_ready = 1;
        start_run();
        wait_pc(8'h03);
        n_tests++;
        if (o_instr_out !== 9'h1FF || o_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_head got instr=%h halt=%b exp 1ff 0", o_instr_out, o_halt);
        end
        i_branch_en = 1; i_taken = 1; i_rel_jump = 8'h10; i_start = 1;
        @(negedge clk);
        i_branch_en = 0; i_taken = 0; i_rel_jump = 8'h00;
        n_tests++;
        if (o_halt !== 1'b1 || o_instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_enter got h=%b v=%b exp 1 0", o_halt, o_instr_valid);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (o_halt !== 1'b1 || o_instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_ignore_start got h=%b v=%b exp 1 0", o_halt, o_instr_valid);
        end
        i_start = 0;
        @(negedge clk);
        n_tests++;
        if (o_halt !== 1'b0 || o_instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_to_idle got h=%b v=%b exp 0 0", o_halt, o_instr_valid);
        end
        start_run();
        @(negedge clk);
        n_tests++;
        if (o_instr_valid !== 1'b1 || o_pc_out !== 8'h00 || o_instr_out !== 9'h010) begin
            n_fail++;
            $display("FAIL halt_restart got v=%b pc=%h instr=%h exp 1 00 010",
                     o_instr_valid, o_pc_out, o_instr_out);
        end
        rom[3] = 9'h013;
    endtask

    task automatic test_async_reset();
        do_reset();
        start_run();
        repeat (3) @(negedge clk);
        n_tests++;
        if (o_instr_valid !== 1'b1 || o_rom_addr !== 8'h02) begin
            n_fail++;
            $display("FAIL areset_pre got v=%b addr=%h exp 1 02", o_instr_valid, o_rom_addr);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({o_instr_valid, o_halt, o_rom_addr, o_instr_out, o_pc_out} !== '0) begin
            n_fail++;
            $display("FAIL areset_outputs got v=%b h=%b a=%h i=%h p=%h exp all 0",
                     o_instr_valid, o_halt, o_rom_addr, o_instr_out, o_pc_out);
        end
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (o_instr_valid !== 1'b0 || o_rom_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_quiet got v=%b addr=%h exp 0 00", o_instr_valid, o_rom_addr);
        end
        start_run();
        @(negedge clk);
        n_tests++;
        if (o_instr_valid !== 1'b1 || o_pc_out !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_restart got v=%b pc=%h exp 1 00", o_instr_valid, o_pc_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 9'(16 + i);
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
